// File: rtl/uart_cmd_pkg.sv
// Shared constants, FSM state type and hex helpers for the UART command parser.
package uart_cmd_pkg;

  localparam logic [7:0] AsciiCr = 8'h0D;
  localparam logic [7:0] AsciiLf = 8'h0A;
  localparam logic [7:0] AsciiL  = 8'h4C;
  localparam logic [7:0] AsciiR  = 8'h52;
  localparam logic [7:0] AsciiK  = 8'h4B;
  localparam logic [7:0] AsciiQ  = 8'h3F;

  typedef enum logic [2:0] {
    StIdle,
    StArgHi,
    StArgLo,
    StWaitCr,
    StDiscard,
    StReply
  } state_e;

  function automatic logic is_hex(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
           (c >= 8'h61 && c <= 8'h66);
  endfunction

  // Only meaningful when is_hex(c) is true.
  function automatic logic [3:0] hex_to_nib(input logic [7:0] c);
    logic [7:0] t;
    if (c <= 8'h39)      t = c - 8'h30;
    else if (c <= 8'h46) t = c - 8'h37;
    else                 t = c - 8'h57;
    return t[3:0];
  endfunction

  function automatic logic [7:0] nib_to_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Inter-byte idle counter: expired pulses once the count reaches TIMEOUT_CYCLES-1 while enabled.
module uart_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !enable_i) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = enable_i && (cnt_q == CntMax);

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII command parser: "L<h><l>CR" drives LEDs, "RCR" reports switches, replies over UART TX.
// Optional error statistics output err_cnt is built when UART_CMD_STATS_EN is defined.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic [7:0] sw_in,
  output logic [7:0] led_data,
  output logic       led_we,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
`ifdef UART_CMD_STATS_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  state_e          state_q, state_d;
  logic            read_q, read_d;
  logic [7:0]      arg_q, arg_d;
  logic [7:0]      led_data_q, led_data_d;
  logic            led_we_q, led_we_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic [2:0][7:0] rep_q, rep_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      idx_q, idx_d;
  logic [1:0]      idx_nxt;
  logic            timer_en, expired, err_evt;

  assign timer_en = (state_q == StArgHi) || (state_q == StArgLo) ||
                    (state_q == StWaitCr) || (state_q == StDiscard);

  uart_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (rx_valid),
    .enable_i (timer_en),
    .expired_o(expired)
  );

  assign idx_nxt = idx_q + 2'd1;

  always_comb begin
    state_d    = state_q;
    read_d     = read_q;
    arg_d      = arg_q;
    led_data_d = led_data_q;
    led_we_d   = 1'b0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    rep_d      = rep_q;
    last_d     = last_q;
    idx_d      = idx_q;
    err_evt    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_valid) begin
          if (rx_data == AsciiL) begin
            state_d = StArgHi;
            read_d  = 1'b0;
          end else if (rx_data == AsciiR) begin
            state_d = StWaitCr;
            read_d  = 1'b1;
          end else if (rx_data != AsciiCr && rx_data != AsciiLf) begin
            state_d = StDiscard;
            err_evt = 1'b1;
          end
        end
      end
      StArgHi, StArgLo: begin
        if (rx_valid) begin
          if (is_hex(rx_data)) begin
            if (state_q == StArgHi) begin
              arg_d[7:4] = hex_to_nib(rx_data);
              state_d    = StArgLo;
            end else begin
              arg_d[3:0] = hex_to_nib(rx_data);
              state_d    = StWaitCr;
            end
          end else begin
            state_d = StDiscard;
            err_evt = 1'b1;
          end
        end else if (expired) begin
          state_d = StIdle;
          err_evt = 1'b1;
        end
      end
      StWaitCr, StDiscard: begin
        if (rx_valid) begin
          if (rx_data == AsciiCr) begin
            if (state_q == StDiscard) begin
              rep_d  = {8'h00, AsciiLf, AsciiQ};
              last_d = 2'd1;
            end else if (read_q) begin
              rep_d  = {AsciiLf, nib_to_hex(sw_in[3:0]), nib_to_hex(sw_in[7:4])};
              last_d = 2'd2;
            end else begin
              led_data_d = arg_q;
              led_we_d   = 1'b1;
              rep_d      = {8'h00, AsciiLf, AsciiK};
              last_d     = 2'd1;
            end
            tx_data_d  = rep_d[0];
            tx_valid_d = 1'b1;
            idx_d      = 2'd0;
            state_d    = StReply;
          end else if (state_q == StWaitCr) begin
            state_d = StDiscard;
            err_evt = 1'b1;
          end
        end else if (expired) begin
          state_d = StIdle;
          err_evt = 1'b1;
        end
      end
      StReply: begin
        // Incoming bytes have nowhere to go while replying; they only count as errors.
        if (rx_valid) err_evt = 1'b1;
        if (tx_valid_q && tx_ready) begin
          if (idx_q == last_q) begin
            tx_valid_d = 1'b0;
            idx_d      = 2'd0;
            state_d    = StIdle;
          end else begin
            idx_d     = idx_nxt;
            tx_data_d = (idx_nxt == 2'd2) ? rep_q[2] : rep_q[1];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      read_q     <= 1'b0;
      arg_q      <= 8'h00;
      led_data_q <= 8'h00;
      led_we_q   <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      rep_q      <= '0;
      last_q     <= 2'd0;
      idx_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      read_q     <= read_d;
      arg_q      <= arg_d;
      led_data_q <= led_data_d;
      led_we_q   <= led_we_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rep_q      <= rep_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
    end
  end

  assign led_data = led_data_q;
  assign led_we   = led_we_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != StIdle);

`ifdef UART_CMD_STATS_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_evt && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= 8'h00;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err_evt;
  assign unused_err_evt = err_evt;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: line-level command model plus directed vectors.
module tb_uart_cmd_parser;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] sw_in = 8'h00;
  logic [7:0] led_data;
  logic       led_we;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       busy;
`ifdef UART_CMD_STATS_EN
  logic [7:0] err_cnt;
`endif

  always #5 clk = ~clk;

  uart_cmd_parser #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .sw_in   (sw_in),
    .led_data(led_data),
    .led_we  (led_we),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy    (busy)
`ifdef UART_CMD_STATS_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model: the current command line, expected TX bytes and LED writes.
  logic [7:0] line[$];
  logic [7:0] exp_tx[$];
  logic [7:0] exp_led[$];
  logic [7:0] got[$];
  logic [7:0] model_led = 8'h00;
  int         model_err = 0;
  logic       hold_v = 1'b0;
  logic [7:0] hold_d = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit hexc(input logic [7:0] c);
    return (c >= 48 && c <= 57) || (c >= 65 && c <= 70) || (c >= 97 && c <= 102);
  endfunction

  function automatic logic [3:0] hexv(input logic [7:0] c);
    int v;
    v = (c <= 57) ? c - 48 : (c <= 70) ? c - 55 : c - 87;
    return v[3:0];
  endfunction

  function automatic logic [7:0] hexch(input logic [3:0] n);
    int v;
    v = (n < 10) ? 48 + n : 55 + n;
    return v[7:0];
  endfunction

  function automatic bit full_cmd();
    if (line.size() == 1) return line[0] == "R";
    if (line.size() == 3) return line[0] == "L" && hexc(line[1]) && hexc(line[2]);
    return 1'b0;
  endfunction

  // True for a line that can still grow into a valid command.
  function automatic bit partial_ok();
    if (line.size() == 0) return 1'b1;
    if (line[0] != "L") return 1'b0;
    return line.size() == 1 || (line.size() == 2 && hexc(line[1]));
  endfunction

  task automatic model_rx(input logic [7:0] b);
    if (exp_tx.size() != 0) begin
      model_err++;
      return;
    end
    if (line.size() == 0 && (b == CR || b == LF)) return;
    if (b != CR) begin
      line.push_back(b);
      return;
    end
    if (full_cmd()) begin
      if (line[0] == "R") begin
        exp_tx.push_back(hexch(sw_in[7:4]));
        exp_tx.push_back(hexch(sw_in[3:0]));
        exp_tx.push_back(LF);
      end else begin
        exp_led.push_back({hexv(line[1]), hexv(line[2])});
        exp_tx.push_back("K");
        exp_tx.push_back(LF);
      end
      line.delete();
    end else if (partial_ok()) begin
      line.push_back(b);  // an early CR is just a bad argument; discarding continues
    end else begin
      exp_tx.push_back("?");
      exp_tx.push_back(LF);
      model_err++;
      line.delete();
    end
  endtask

  task automatic model_timeout();
    if (line.size() != 0) begin
      model_err += partial_ok() ? 1 : 2;
      line.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    model_rx(b);
    @(posedge clk);
    #2;
    rx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_tx.size() != 0 || tx_valid) && n < 100) begin
      idle(1);
      n++;
    end
    chk("reply_done_in_time", 32'(n < 100), 32'd1);
  endtask

  task automatic model_reset();
    line.delete();
    exp_tx.delete();
    exp_led.delete();
    model_led = 8'h00;
    model_err = 0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        if (exp_tx.size() == 0) chk("tx_unexpected_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
        else chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
      end
      if (tx_valid && !tx_ready) begin
        if (hold_v) chk("tx_hold_stable", {24'h0, tx_data}, {24'h0, hold_d});
        hold_v = 1'b1;
        hold_d = tx_data;
      end else begin
        hold_v = 1'b0;
      end
      if (led_we) begin
        if (exp_led.size() == 0) chk("led_we_unexpected", 32'd1, 32'd0);
        else model_led = exp_led.pop_front();
      end
      chk("led_data", {24'h0, led_data}, {24'h0, model_led});
    end
  end

  initial begin
    // Reset values
    @(posedge clk);
    #2;
    chk("rst_led_data", {24'h0, led_data}, 32'h00);
    chk("rst_led_we", {31'h0, led_we}, 32'd0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h00);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
`ifdef UART_CMD_STATS_EN
    chk("rst_err_cnt", {24'h0, err_cnt}, 32'h00);
`endif
    rst = 1'b0;
    idle(2);

    // LED write with lowercase hex, back-to-back reply bytes
    got.delete();
    send("L"); send("a"); send("5");
    chk("l_busy", {31'h0, busy}, 32'd1);
    send(CR);
    chk("l_led_we", {31'h0, led_we}, 32'd1);
    chk("l_tx_valid_rise", {31'h0, tx_valid}, 32'd1);
    chk("l_tx_first", {24'h0, tx_data}, 32'h4B);
    chk("l_led_value", {24'h0, led_data}, 32'hA5);
    idle(1);
    chk("l_led_we_pulse", {31'h0, led_we}, 32'd0);
    chk("l_tx_second_valid", {31'h0, tx_valid}, 32'd1);
    chk("l_tx_second", {24'h0, tx_data}, 32'h0A);
    idle(1);
    chk("l_tx_done", {31'h0, tx_valid}, 32'd0);
    chk("l_idle", {31'h0, busy}, 32'd0);
    chk("l_got_n", got.size(), 32'd2);
    chk("l_got0", {24'h0, got[0]}, 32'h4B);
    chk("l_got1", {24'h0, got[1]}, 32'h0A);

    // Switch read with backpressure; switch changes and a stray byte after CR do not matter
    got.delete();
    sw_in = 8'h3C;
    tx_ready = 1'b0;
    send("R"); send(CR);
    sw_in = 8'hFF;
    chk("r_tx_first", {24'h0, tx_data}, 32'h33);
    send("X");
    idle(4);
    chk("r_tx_held", {24'h0, tx_data}, 32'h33);
    chk("r_tx_valid_held", {31'h0, tx_valid}, 32'd1);
    tx_ready = 1'b1;
    idle(1);
    chk("r_tx_second", {24'h0, tx_data}, 32'h43);
    idle(1);
    chk("r_tx_third", {24'h0, tx_data}, 32'h0A);
    idle(1);
    chk("r_tx_done", {31'h0, tx_valid}, 32'd0);
    chk("r_got_n", got.size(), 32'd3);
    chk("r_got0", {24'h0, got[0]}, 32'h33);
    chk("r_got1", {24'h0, got[1]}, 32'h43);
    chk("r_got2", {24'h0, got[2]}, 32'h0A);

    // Bad hex digit
    got.delete();
    send("L"); send("G"); send("1"); send(CR);
    wait_done();
    chk("bad_led_kept", {24'h0, led_data}, 32'hA5);
    chk("bad_got_n", got.size(), 32'd2);
    chk("bad_got0", {24'h0, got[0]}, 32'h3F);
    chk("bad_got1", {24'h0, got[1]}, 32'h0A);

    // Timeout boundary: still busy after 15 idle cycles, back in idle after 16
    got.delete();
    send("L"); send("1");
    idle(15);
    chk("to_busy_15", {31'h0, busy}, 32'd1);
    idle(1);
    chk("to_idle_16", {31'h0, busy}, 32'd0);
    model_timeout();
    idle(4);
    chk("to_no_tx", got.size(), 32'd0);
    sw_in = 8'h5A;
    send("R"); send(CR);
    wait_done();
    chk("to_after_got_n", got.size(), 32'd3);
    chk("to_after_got0", {24'h0, got[0]}, 32'h35);
    chk("to_after_got1", {24'h0, got[1]}, 32'h41);

    // A byte landing on the expiry cycle wins over the timeout
    got.delete();
    send("L"); send("1");
    idle(15);
    send("2");
    chk("win_busy", {31'h0, busy}, 32'd1);
    send(CR);
    chk("win_led_we", {31'h0, led_we}, 32'd1);
    chk("win_led", {24'h0, led_data}, 32'h12);
    wait_done();
    chk("win_got0", {24'h0, got[0]}, 32'h4B);
`ifdef UART_CMD_STATS_EN
    chk("err_cnt_model", {24'h0, err_cnt}, 32'(model_err));
`endif

    // Unknown leading byte discards the whole line
    rst = 1'b1;
    model_reset();
    idle(1);
    rst = 1'b0;
    got.delete();
    send("Z"); send(LF); send("L"); send("0"); send("F"); send(CR);
    wait_done();
    chk("z_led_kept", {24'h0, led_data}, 32'h00);
    chk("z_got_n", got.size(), 32'd2);
    chk("z_got0", {24'h0, got[0]}, 32'h3F);
    chk("z_got1", {24'h0, got[1]}, 32'h0A);
`ifdef UART_CMD_STATS_EN
    chk("z_err_cnt", {24'h0, err_cnt}, 32'd1);
`endif

    // Reset during the second reply byte aborts the reply
    got.delete();
    send("R"); send(CR);
    chk("ra_first", {24'h0, tx_data}, 32'h35);
    idle(1);
    chk("ra_second", {24'h0, tx_data}, 32'h41);
    rst = 1'b1;
    model_reset();
    idle(1);
    chk("ra_tx_valid", {31'h0, tx_valid}, 32'd0);
    chk("ra_tx_data", {24'h0, tx_data}, 32'h00);
    chk("ra_led_data", {24'h0, led_data}, 32'h00);
    chk("ra_led_we", {31'h0, led_we}, 32'd0);
    chk("ra_busy", {31'h0, busy}, 32'd0);
    rst = 1'b0;
    idle(4);
    chk("ra_stays_idle", {31'h0, tx_valid}, 32'd0);
    chk("ra_got_n", got.size(), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000: inter-byte timeout in clk cycles; a partial command is abandoned after this many cycles without a received byte.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 rx_data  input  8  received byte from the UART receiver.
REQ-005 rx_valid  input  1  one-cycle strobe qualifying rx_data; no backpressure exists.
REQ-006 sw_in  input  8  slide-switch value to be reported.
REQ-007 led_data  output  8  registered LED value.
REQ-008 led_we  output  1  one-cycle pulse when led_data is updated.
REQ-009 tx_data  output  8  reply byte to the UART transmitter.
REQ-010 tx_valid  output  1  reply byte valid.
REQ-011 tx_ready  input  1  transmitter accepts tx_data when tx_valid and tx_ready are both high.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 Commands are ASCII, terminated by CR (0x0D): "L<h><l>CR" sets the LEDs; "RCR" reads the switches.
REQ-014 Hex digits 0-9, A-F and a-f are accepted; replies use uppercase only.
REQ-015 FSM states: IDLE, ARG_HI, ARG_LO, WAIT_CR, DISCARD, REPLY.
REQ-016 IDLE transitions: 'L' -> ARG_HI; 'R' -> WAIT_CR with the read flag set; LF (0x0A) and CR are ignored and stay in IDLE; any other byte -> DISCARD.
REQ-017 ARG_HI and ARG_LO capture one nibble each (high nibble first); a non-hex byte -> DISCARD.
REQ-018 WAIT_CR: CR -> REPLY; any other byte -> DISCARD.
REQ-019 DISCARD drops bytes until CR, then loads the reply "?" LF (0x3F 0x0A) and enters REPLY.
REQ-020 L-command on CR: led_data and led_we update in the cycle after CR is accepted; the reply is "K" LF (0x4B 0x0A).
REQ-021 R-command on CR: sw_in is sampled in the CR-accept cycle; the reply is the high hex char, the low hex char, then LF.
REQ-022 tx_valid rises in the cycle after CR is accepted, i.e. the same cycle as led_we.
REQ-023 tx_data is held stable while tx_valid is high and tx_ready is low; the next byte is presented in the cycle after a transfer, so zero idle cycles occur when tx_ready stays high.
REQ-024 After the LF transfer, tx_valid drops and the FSM returns to IDLE.
REQ-025 rx_valid bytes arriving in REPLY are dropped without affecting the reply.
REQ-026 The timeout counter clears on every rx_valid.
REQ-027 In ARG_HI, ARG_LO, WAIT_CR or DISCARD, if the counter reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE silently: no reply, no led_we.
REQ-028 The timeout is inactive in IDLE and REPLY.
REQ-029 Timeout expiry in the same cycle as rx_valid: the byte wins and the timeout is ignored.

Reset
REQ-030 Reset values: led_data=0x00, led_we=0, tx_data=0x00, tx_valid=0, busy=0, FSM=IDLE, timeout counter=0, reply index=0.
REQ-031 Reset asserted mid-command or mid-reply aborts immediately; the remaining reply bytes are never sent.

Configuration
REQ-032 Macro UART_CMD_STATS_EN defined: an extra output err_cnt (8 bits) counts DISCARD entries, bytes dropped in REPLY, and timeouts.
REQ-033 err_cnt saturates at 0xFF and is reset to 0; simultaneous events in one cycle count as 1.
REQ-034 Macro UART_CMD_STATS_EN undefined: the err_cnt port and its counter do not exist; all other behaviour is identical.

Structure
REQ-035 Shared package uart_cmd_pkg holds:
- the ASCII constants (CR, LF, 'L', 'R', 'K', '?');
- the FSM state enum;
- the hex-to-nibble and nibble-to-hex functions.
REQ-036 Sub-module uart_idle_timer implements the TIMEOUT_CYCLES counter, with clear and enable inputs and an expired output.
REQ-037 The reply buffer (up to 3 bytes plus index) stays inside uart_cmd_parser.

Verification
REQ-038 Send "L", "a", "5", CR with tx_ready=1: led_data=0xA5 with a one-cycle led_we; tx emits 0x4B then 0x0A.
REQ-039 sw_in=0x3C, send "R", CR, and hold tx_ready low for 5 cycles: tx_data=0x33 held stable, then 0x43, then 0x0A; led_we never asserts.
REQ-040 Send "L", "G", "1", CR: no led_we, led_data unchanged; reply is 0x3F 0x0A.
REQ-041 TIMEOUT_CYCLES=16: send "L", "1", then idle for 20 cycles: busy drops, no tx; a following "R", CR returns a normal reply.
REQ-042 Send "Z" LF "L" "0" "F" CR with UART_CMD_STATS_EN defined: "Z" enters DISCARD and the following bytes through CR are discarded, so led_data is unchanged; reply is 0x3F 0x0A; err_cnt=1.
REQ-043 Assert rst during the second reply byte: tx_valid=0 on the next cycle and all outputs are at their reset values.
